// File: rtl/fetch_stage.sv
// Instruction-fetch front end: credit-limited req/gnt/rvalid fetch into an
// in-order queue of {inst, pc}, with redirect flush and wrong-path discard.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam int unsigned   CW      = AW + 1;
  localparam logic [31:0]   NOP     = 32'h0000_0013;
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic [CW+1:0] credit_used;
  logic          head_valid;
  logic          grant;
  logic          drop;
  logic          push;
  logic          pop;

  always_comb begin
    credit_used = {2'b00, occ_q} + {2'b00, outst_q} + {2'b00, disc_q};
    imem_req    = !rst && !redirect && (credit_used < DEPTH_W);
    imem_addr   = fetch_pc_q;

    head_valid  = (occ_q != '0) && !redirect;
    inst_valid  = head_valid;
    inst        = head_valid ? inst_mem_q[rd_ptr_q] : NOP;
    pc          = head_valid ? pc_mem_q[rd_ptr_q]   : '0;

    grant       = imem_req && imem_gnt;
    drop        = imem_rvalid && (disc_q != '0);
    // A response with nothing outstanding is a memory protocol error; ignore it.
    push        = imem_rvalid && (disc_q == '0) && (outst_q != '0);
    pop         = head_valid && !stall;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    occ_d      = occ_q;
    outst_d    = outst_q;
    disc_d     = disc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      resp_pc_d  = redirect_pc & 32'hFFFF_FFFC;
      occ_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // Everything still in flight becomes wrong-path; this cycle's word is already gone.
      disc_d     = outst_q + disc_q - CW'(imem_rvalid);
      outst_d    = '0;
    end else begin
      fetch_pc_d = grant ? fetch_pc_q + 32'd4 : fetch_pc_q;
      resp_pc_d  = push  ? resp_pc_q  + 32'd4 : resp_pc_q;
      outst_d    = outst_q + CW'(grant) - CW'(push);
      disc_d     = disc_q - CW'(drop);
      occ_d      = occ_q + CW'(push) - CW'(pop);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      wr_ptr_d   = wr_ptr_q + AW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      occ_q      <= '0;
      outst_q    <= '0;
      disc_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      occ_q      <= occ_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !redirect && push) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model plus an in-order
// variable-latency instruction memory, driven by directed and random phases.
module tb_fetch_stage;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .inst_valid(inst_valid), .inst(inst), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] i; logic [31:0] p; } ent_t;
  typedef struct { logic [31:0] d; int unsigned due; } pend_t;

  ent_t        mq[$];
  pend_t       pend[$];
  logic [31:0] m_fpc, m_rpc;
  int unsigned m_out, m_disc;
  int unsigned cyc    = 0;
  bit          chk_en = 1'b0;
  int unsigned n_cmp  = 0;
  int unsigned n_err  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic [31:0] rpc,
                      input logic st, input logic g, input int unsigned lat,
                      input string ph);
    logic        rv, reqm, show;
    logic [31:0] rdv;
    ent_t        e;
    pend_t       p;
    @(negedge clk);
    rv  = !r && (pend.size() > 0) && (pend[0].due <= cyc);
    rdv = rv ? pend[0].d : $urandom();
    rst = r; redirect = rd; redirect_pc = rpc; stall = st;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rdv;
    #1;
    reqm = !r && !rd && ((mq.size() + m_out + m_disc) < DEPTH);
    show = (mq.size() != 0) && !rd;
    if (chk_en) begin
      chk({ph, ":req"}, 32'(imem_req), 32'(reqm));
      if (reqm) chk({ph, ":addr"}, imem_addr, m_fpc);
      chk({ph, ":valid"}, 32'(inst_valid), 32'(show));
      chk({ph, ":inst"}, inst, show ? mq[0].i : NOP);
      chk({ph, ":pc"},   pc,   show ? mq[0].p : 32'h0);
    end
    if (r) begin
      m_fpc = RESET_PC; m_rpc = RESET_PC;
      mq.delete(); pend.delete();
      m_out = 0; m_disc = 0;
      chk_en = 1'b1;
    end else if (rd) begin
      if (rv) void'(pend.pop_front());
      mq.delete();
      m_fpc  = {rpc[31:2], 2'b00};
      m_rpc  = m_fpc;
      m_disc = m_out + m_disc - (rv ? 1 : 0);
      m_out  = 0;
    end else begin
      if (show && !st) void'(mq.pop_front());
      if (rv) begin
        void'(pend.pop_front());
        if (m_disc > 0) m_disc--;
        else begin
          m_out--;
          e.i = rdv; e.p = m_rpc;
          mq.push_back(e);
          m_rpc += 32'd4;
        end
      end
      if (reqm && g) begin
        p.d = $urandom(); p.due = cyc + lat;
        pend.push_back(p);
        m_fpc += 32'd4;
        m_out++;
      end
    end
    cyc++;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    repeat (3) step(1, 0, 0, 0, 0, 1, "reset");
    repeat (20) step(0, 0, 0, 0, 1, 1, "stream");
    repeat (4) step(0, 0, 0, 1, 1, 1, "stall");
    repeat (8) step(0, 0, 0, 0, 1, 1, "unstall");

    // Two grants in flight on a slow memory, then redirect to 0x100.
    repeat (2) step(0, 0, 0, 0, 1, 3, "slow");
    step(0, 1, 32'h0000_0100, 0, 1, 3, "redir100");
    repeat (8) step(0, 0, 0, 0, 1, 1, "after100");

    step(0, 1, 32'h0000_0103, 1, 1, 1, "redir103");
    repeat (6) step(0, 0, 0, 0, 1, 1, "after103");

    // Redirect while a response lands and a pop is pending.
    repeat (3) step(0, 0, 0, 0, 1, 1, "prefill");
    step(0, 1, 32'h0000_0200, 0, 1, 1, "redir_rv");
    repeat (6) step(0, 0, 0, 0, 1, 1, "after200");

    step(0, 1, 32'hFFFF_FFFC, 0, 1, 1, "redir_wrap");
    repeat (6) step(0, 0, 0, 0, 1, 1, "wrap");

    repeat (300) begin
      step(0, ($urandom_range(0, 9) == 0), $urandom(), ($urandom_range(0, 3) == 0),
           $urandom_range(0, 1) == 1, $urandom_range(1, 3), "rand");
    end

    repeat (3) step(0, 0, 0, 0, 1, 2, "pre_rst");
    step(1, 0, 0, 0, 1, 2, "mid_rst");
    repeat (2) step(0, 0, 0, 0, 0, 1, "post_rst");
    repeat (200) begin
      step(0, ($urandom_range(0, 15) == 0), $urandom(), ($urandom_range(0, 2) == 0),
           $urandom_range(0, 3) != 0, $urandom_range(1, 4), "rand2");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
